// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_param
// Purpose  : Serial pattern detector with loadable pattern, selectable overlap
//            and a saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
    parameter int              PAT_W     = 4,
    parameter logic [PAT_W-1:0] RESET_PAT = 4'b1011,
    parameter int              CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inp_valid,
    input  logic             inp_bit,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             overlap_en,
    input  logic             clr_count,
    output logic             seq_seen,
    output logic [CNT_W-1:0] count,
    output logic             count_sat
);

    localparam int               c_FILL_W = $clog2(PAT_W + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_W-1:0]    pat_q;
    logic [PAT_W-1:0]    hist_q;
    logic [PAT_W-1:0]    hist_d;
    logic [c_FILL_W-1:0] fill_q;
    logic [c_FILL_W-1:0] fill_d;
    logic                seen_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                sat_q;
    logic                sat_d;
    logic                w_match;

    always_comb begin
        hist_d  = {hist_q[PAT_W-2:0], inp_bit};
        fill_d  = (fill_q == c_FILL_FULL) ? c_FILL_FULL : fill_q + 1'b1;
        // A pattern load takes the cycle, so its inp_bit can never complete a match.
        w_match = inp_valid && !pat_load && (fill_d == c_FILL_FULL) && (hist_d == pat_q);

        count_d = count_q;
        sat_d   = sat_q;
        if (clr_count) begin
            count_d = w_match ? CNT_W'(1) : '0;
            sat_d   = 1'b0;
        end else begin
            if (w_match && (count_q != c_CNT_MAX)) begin
                count_d = count_q + 1'b1;
            end
            sat_d = sat_q | (count_d == c_CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q   <= RESET_PAT;
            hist_q  <= '0;
            fill_q  <= '0;
            seen_q  <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            seen_q  <= w_match;
            count_q <= count_d;
            sat_q   <= sat_d;
            if (pat_load) begin
                pat_q  <= pattern_in;
                fill_q <= '0;
            end else if (inp_valid) begin
                hist_q <= hist_d;
                // Non-overlapping mode discards history so the next match needs PAT_W fresh bits.
                if (w_match && !overlap_en) begin
                    fill_q <= '0;
                end else begin
                    fill_q <= fill_d;
                end
            end
        end
    end

    assign seq_seen  = seen_q;
    assign count     = count_q;
    assign count_sat = sat_q;

endmodule
`default_nettype wire
